// File: rtl/shared_adder_arbiter.sv
// Time-shares one registered adder among NREQ requesters.
// Round-robin grant with operand capture in stage 1; the add and a one-hot ack come in stage 2.
module shared_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 13,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      sum,
    output logic                  carry,
    output logic                  busy
);

    function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [NREQ-1:0]  pending;
    logic [NREQ-1:0]  pending_next;
    logic [NREQ-1:0]  elig;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic             grant_vld;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;

    logic             vld_p1;
    logic [IDW-1:0]   id_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    // A requester whose ack is showing this cycle is masked, so regrant is one cycle later.
    assign elig = req & ~pending & ~ack;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int            idx;
            logic [IDW-1:0] sel;
            idx = (int'(ptr) + k) % NREQ;
            sel = IDW'(idx);
            if (!grant_vld && elig[sel]) begin
                grant_vld = 1'b1;
                grant_id  = sel;
            end
        end
    end

    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                grant_a = op_a[k*WIDTH +: WIDTH];
                grant_b = op_b[k*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    // The clear of a completing id and the set of a new grant are independent.
    always_comb begin
        pending_next = pending;
        if (vld_p1)
            pending_next[id_p1] = 1'b0;
        if (grant_vld)
            pending_next[grant_id] = 1'b1;
    end

    // Stage 1: grant and operand capture; stage 2: add and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            pending <= '0;
            ptr     <= '0;
            ack     <= '0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            vld_p1  <= grant_vld;
            pending <= pending_next;
            if (grant_vld) begin
                id_p1 <= grant_id;
                ptr   <= ptr_next;
            end
            ack <= vld_p1 ? (NREQ'(1) << id_p1) : '0;
            if (vld_p1)
                {carry, sum} <= add_wrap(a_p1, b_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant_vld) begin
            a_p1 <= grant_a;
            b_p1 <= grant_b;
        end
    end

    assign busy = vld_p1 | (|ack);

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter: single-transaction vector table
// plus hand-written reset, fairness, back-to-back and protocol sequences.
module tb_shared_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 13;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      sum;
    logic                  carry;
    logic                  busy;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*WIDTH +: WIDTH] = a_arr[i];
            op_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
    end

    shared_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op_a  (op_a),
        .op_b  (op_b),
        .ack   (ack),
        .sum   (sum),
        .carry (carry),
        .busy  (busy)
    );

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_carry;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
    endtask

    initial begin
        logic [NREQ-1:0] exp_ack [7];
        logic [WIDTH-1:0] exp_s  [7];

        vecs[0] = '{2,  13'd100,  13'd23,   13'd123,  1'b0};
        vecs[1] = '{0,  13'd8191, 13'd1,    13'd0,    1'b1};
        vecs[2] = '{1,  13'd5000, 13'd5000, 13'd1808, 1'b1};
        vecs[3] = '{3,  13'd4095, 13'd4096, 13'd8191, 1'b0};
        vecs[4] = '{0,  13'd0,    13'd0,    13'd0,    1'b0};
        vecs[5] = '{1,  13'd8000, 13'd500,  13'd308,  1'b1};

        rst_n = 1'b0;
        req   = '0;
        clear_ops();
        @(negedge clk);
        @(negedge clk);
        check("reset_ack",   32'(ack),   32'd0);
        check("reset_sum",   32'(sum),   32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;

        // Single transactions from idle: ack two cycles after the request.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            req = '0;
            req[vecs[v].id] = 1'b1;
            a_arr[vecs[v].id] = vecs[v].a;
            b_arr[vecs[v].id] = vecs[v].b;
            @(negedge clk);
            check($sformatf("vec%0d_ack_t1", v), 32'(ack), 32'd0);
            check($sformatf("vec%0d_busy_t1", v), 32'(busy), 32'd1);
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_ack", v), 32'(ack), 32'(4'b0001 << vecs[v].id));
            check($sformatf("vec%0d_sum", v), 32'(sum), 32'(vecs[v].exp_sum));
            check($sformatf("vec%0d_carry", v), 32'(carry), 32'(vecs[v].exp_carry));
            @(negedge clk);
            check($sformatf("vec%0d_ack_t3", v), 32'(ack), 32'd0);
            check($sformatf("vec%0d_busy_t3", v), 32'(busy), 32'd0);
            check($sformatf("vec%0d_sum_hold", v), 32'(sum), 32'(vecs[v].exp_sum));
        end

        // Reset while stage 1 holds a granted op: outputs clear at once, op is dropped.
        @(negedge clk);
        req = 4'b0001;
        a_arr[0] = 13'd77;
        b_arr[0] = 13'd1;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check("rstmid_ack",  32'(ack),  32'd0);
        check("rstmid_sum",  32'(sum),  32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_noack%0d", k), 32'(ack), 32'd0);
            check($sformatf("rstmid_idle%0d", k), 32'(busy), 32'd0);
        end

        // Fairness: all four held with ptr at 0 after reset.
        exp_ack[1] = 4'b0000; exp_s[1] = 13'd0;
        exp_ack[2] = 4'b0001; exp_s[2] = 13'd11;
        exp_ack[3] = 4'b0010; exp_s[3] = 13'd22;
        exp_ack[4] = 4'b0100; exp_s[4] = 13'd33;
        exp_ack[5] = 4'b1000; exp_s[5] = 13'd44;
        exp_ack[6] = 4'b0001; exp_s[6] = 13'd11;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 13'(10 * (i + 1));
            b_arr[i] = 13'(i + 1);
        end
        req = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("rr_ack_t%0d", k), 32'(ack), 32'(exp_ack[k]));
            if (k >= 2)
                check($sformatf("rr_sum_t%0d", k), 32'(sum), 32'(exp_s[k]));
            if (k == 5)
                req = '0;
        end
        @(negedge clk);
        check("rr_ack_end",  32'(ack),  32'd0);
        check("rr_busy_end", 32'(busy), 32'd0);

        // Back-to-back on requester 1: grants at t, t+3, t+6 with operands of those cycles.
        clear_ops();
        @(negedge clk);
        req = 4'b0010;
        a_arr[1] = 13'd0;
        b_arr[1] = 13'd1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a_arr[1] = 13'(100 * k);
            if (k == 2 || k == 5 || k == 8) begin
                check($sformatf("b2b_ack_t%0d", k), 32'(ack), 32'b0010);
                check($sformatf("b2b_sum_t%0d", k), 32'(sum), 32'(100 * (k - 2) + 1));
            end else begin
                check($sformatf("b2b_noack_t%0d", k), 32'(ack), 32'd0);
            end
            if (k == 7)
                req = '0;
        end
        @(negedge clk);
        check("b2b_ack_end",  32'(ack),  32'd0);
        @(negedge clk);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // Protocol: req[3] dropped after grant and operands changed; result uses grant-cycle values.
        @(negedge clk);
        req = 4'b1000;
        a_arr[3] = 13'd50;
        b_arr[3] = 13'd60;
        @(negedge clk);
        req = '0;
        a_arr[3] = 13'd999;
        b_arr[3] = 13'd999;
        @(negedge clk);
        check("proto_ack",   32'(ack),   32'b1000);
        check("proto_sum",   32'(sum),   32'd110);
        check("proto_carry", 32'(carry), 32'd0);
        @(negedge clk);
        check("proto_ack_end", 32'(ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
